uart_rx_param: RTL and testbench
================================

Name:
uart_rx_param

Overview:
Parametrised next-generation UART receiver for the literisc peripheral bus. It oversamples the serial line using the shared baud-rate generator tick and reassembles LSB-first words of configurable width. Configurable options: parity, stop-bit count and oversampling ratio. It adds input synchronisation, start-bit glitch rejection, 3-sample majority voting, parity/framing/overrun error flags and break detection. Output is a held word with a ready/ack handshake toward the CPU or FIFO.

Parameters:
DBITS, 8, data bits per word; legal 5..9
OVERSAMPLE, 16, sample_tick pulses per bit period; legal 8..32, even
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked; legal 1 or 2

Ports:
clk_100MHz  in  1  system clock; all state on its rising edge
reset  in  1  asynchronous, active-high reset
rx  in  1  asynchronous serial line; idles high
sample_tick  in  1  one-cycle oversampling strobe from baud generator
data_ack  in  1  consumer has taken data_out; clears data_ready and flags
data_ready  out  1  word held in data_out is valid
data_out  out  DBITS  received word; bit 0 = first data bit on the line
parity_err  out  1  parity mismatch on the held word (always 0 when PARITY = 0)
frame_err  out  1  a stop-bit sample was 0
overrun_err  out  1  a word completed while data_ready was already 1 and not being acked
break_det  out  1  all data, parity and stop samples were 0
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, active-high): state = IDLE, rx synchroniser = 1, all counters = 0, data_out = 0. data_ready, parity_err, frame_err, overrun_err and break_det = 0.
- rx passes through a 2-flop synchroniser (rxs); all decisions use rxs.
- IDLE: when rxs = 0, go to START and clear tick_cnt. sample_tick is not needed.
- START: on each sample_tick, tick_cnt increments. At tick_cnt = OVERSAMPLE/2-1:
  - rxs = 1 → glitch; return to IDLE, no flags.
  - rxs = 0 → go to DATA with tick_cnt = 0 and bit_cnt = 0.
- DATA, PARITY, STOP (bit periods):
  - tick_cnt counts 0..OVERSAMPLE-1 on sample_tick.
  - rxs is captured at tick_cnt = OVERSAMPLE-3, OVERSAMPLE-2 and OVERSAMPLE-1.
  - The bit value is the 2-of-3 majority, resolved at tick_cnt = OVERSAMPLE-1; tick_cnt then wraps to 0.
- DATA: the bit is shifted into bit DBITS-1 of shift_reg, which shifts right. After bit_cnt = DBITS-1, go to PARITY if PARITY != 0, else STOP.
- PARITY: for even, error if XOR(data, pbit) = 1; for odd, error if it = 0. Then go to STOP with stop_cnt = 0.
- STOP:
  - Each stop bit sampled 0 latches a pending frame error.
  - After STOP_BITS periods the word completes (complete pulse) on that sample_tick cycle.
  - Next state: IDLE if the last stop sample = 1, else RECOVER.
- RECOVER: wait until rxs = 1, then go to IDLE. This prevents a held-low line or break from retriggering.
- Completion (registered; outputs change on the clock edge ending the complete cycle):
  - data_out ← shift_reg.
  - parity_err, frame_err, break_det ← values for this frame.
  - overrun_err ← 1 if data_ready = 1 and data_ack = 0; otherwise overrun_err is retained.
  - data_ready ← 1.
- data_ack without completion: clears data_ready and all four flags. data_ack while data_ready = 0 has no effect.
- Completion and data_ack in the same cycle: completion wins; data_ready stays 1 with the new frame's flags; overrun_err ← 0.
- break_det = 1 implies frame_err = 1.
- Latency:
  - Sampling latency: 2 clocks from the synchroniser plus the clock-edge quantisation.
  - data_ready rises 1 clock after the sample_tick at the centre of the final stop bit.
- sample_tick must be ≤ 1 per clock. With sample_tick held low, all states hold except IDLE and RECOVER.
- Reset mid-frame aborts the frame with no partial output.

Test Plan:
- Defaults, tick every 4 clocks. Send 0xA5, 8N1, then ack → data_out = 0xA5, data_ready = 1, all flags 0; after ack, data_ready = 0.
- Pulse rx low for 5 ticks (< OVERSAMPLE/2), then high → returns to IDLE, data_ready stays 0, busy low within 10 ticks of rx rising.
- PARITY = 1, DBITS = 7. Send 0x55 with parity bit 1 → data_out = 0x55, parity_err = 1. Resend with parity 0 → parity_err = 0.
- Send 0x3C with stop bit 0, then rx high → frame_err = 1, data_out = 0x3C. Next frame 0x12 after ack → frame_err = 0.
- Hold rx low for 20 bit periods → one word 0x00 with frame_err = 1 and break_det = 1, busy stays high until rx returns high; no second word.
- Send 0x11 then 0x22 without ack → data_out = 0x22, overrun_err = 1. Separately, ack exactly on 0x22's completion cycle → overrun_err = 0, data_ready = 1. Flip one mid-bit sample per bit via 1-tick glitch → word unchanged.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Receiver-side bus bundle: serial line and baud tick in, held word with
// ready/ack handshake and error flags out.
interface uart_rx_param_if #(
    parameter int DBITS = 8
);
    logic             rx;
    logic             sample_tick;
    logic             data_ack;
    logic             data_ready;
    logic [DBITS-1:0] data_out;
    logic             parity_err;
    logic             frame_err;
    logic             overrun_err;
    logic             break_det;
    logic             busy;

    modport master (
        output rx, sample_tick, data_ack,
        input  data_ready, data_out, parity_err, frame_err, overrun_err, break_det, busy
    );

    modport slave (
        input  rx, sample_tick, data_ack,
        output data_ready, data_out, parity_err, frame_err, overrun_err, break_det, busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-flop rx synchroniser, start-bit glitch
// rejection, 3-sample majority per bit, parity/framing/overrun/break flags
// and a held output word released by data_ack.
module uart_rx_param #(
    parameter int DBITS      = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic           clk_100MHz,
    input  logic           reset,
    uart_rx_param_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DBITS);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE - 3);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE - 2);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DBITS - 1);
    localparam logic          S_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, RECOVER} state_t;

    state_t           state, state_n;
    logic             rx_p0, rxs;
    logic [TW-1:0]    tick_cnt, tick_n;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic             stop_cnt, stop_n;
    logic [DBITS-1:0] shift_reg, shift_n;
    logic [1:0]       smp, smp_n;
    logic             par_acc, par_n;
    logic             perr_p, perr_pn, ferr_p, ferr_pn, brk_p, brk_pn;
    logic             complete, bit_v, bit_end;
    logic             fin_perr, fin_ferr, fin_brk;
    logic             ready_q, perr_q, ferr_q, ovr_q, brk_q;
    logic [DBITS-1:0] dout_q;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Even parity fails on odd total ones; odd parity fails on even total.
    function automatic logic parity_bad(input logic acc, input logic pbit);
        if (PARITY == 1) return acc ^ pbit;
        else             return ~(acc ^ pbit);
    endfunction

    // Bring the asynchronous line into the clock domain; idle level is 1.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_p0 <= bus.rx;
            rxs   <= rx_p0;
        end
    end

    // Receiver state and per-frame working registers.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            shift_reg <= '0;
            smp       <= '0;
            par_acc   <= 1'b0;
            perr_p    <= 1'b0;
            ferr_p    <= 1'b0;
            brk_p     <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_n;
            bit_cnt   <= bit_n;
            stop_cnt  <= stop_n;
            shift_reg <= shift_n;
            smp       <= smp_n;
            par_acc   <= par_n;
            perr_p    <= perr_pn;
            ferr_p    <= ferr_pn;
            brk_p     <= brk_pn;
        end
    end

    // Next-state, bit sampling and per-frame error accumulation.
    always_comb begin
        state_n  = state;
        tick_n   = tick_cnt;
        bit_n    = bit_cnt;
        stop_n   = stop_cnt;
        shift_n  = shift_reg;
        smp_n    = smp;
        par_n    = par_acc;
        perr_pn  = perr_p;
        ferr_pn  = ferr_p;
        brk_pn   = brk_p;
        complete = 1'b0;
        fin_perr = perr_p;
        fin_ferr = ferr_p;
        fin_brk  = brk_p;
        bit_v    = maj3(smp[0], smp[1], rxs);
        bit_end  = bus.sample_tick && (tick_cnt == T_LAST);

        // Shared bit-period timing for DATA, PAR and STOP.
        if ((state == DATA || state == PAR || state == STOP) && bus.sample_tick) begin
            tick_n = bit_end ? '0 : tick_cnt + TW'(1);
            if (tick_cnt == T_S0) smp_n[0] = rxs;
            if (tick_cnt == T_S1) smp_n[1] = rxs;
        end

        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n = START;
                    tick_n  = '0;
                end
            end
            START: begin
                if (bus.sample_tick) begin
                    if (tick_cnt == T_HALF) begin
                        if (rxs) begin
                            state_n = IDLE;
                        end else begin
                            state_n = DATA;
                            tick_n  = '0;
                            bit_n   = '0;
                            par_n   = 1'b0;
                            perr_pn = 1'b0;
                            ferr_pn = 1'b0;
                            brk_pn  = 1'b1;
                        end
                    end else begin
                        tick_n = tick_cnt + TW'(1);
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = {bit_v, shift_reg[DBITS-1:1]};
                    par_n   = par_acc ^ bit_v;
                    if (bit_v) brk_pn = 1'b0;
                    if (bit_cnt == B_LAST) begin
                        state_n = (PARITY != 0) ? PAR : STOP;
                        stop_n  = 1'b0;
                    end else begin
                        bit_n = bit_cnt + BW'(1);
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    perr_pn = parity_bad(par_acc, bit_v);
                    if (bit_v) brk_pn = 1'b0;
                    state_n = STOP;
                    stop_n  = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    fin_ferr = ferr_p | ~bit_v;
                    fin_brk  = brk_p & ~bit_v;
                    ferr_pn  = fin_ferr;
                    brk_pn   = fin_brk;
                    if (stop_cnt == S_LAST) begin
                        complete = 1'b1;
                        state_n  = bit_v ? IDLE : RECOVER;
                    end else begin
                        stop_n = 1'b1;
                    end
                end
            end
            RECOVER: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Output hold register: completion loads a new word, ack releases it.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            dout_q  <= '0;
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else if (complete) begin
            dout_q  <= shift_reg;
            ready_q <= 1'b1;
            perr_q  <= fin_perr;
            ferr_q  <= fin_ferr;
            brk_q   <= fin_brk;
            ovr_q   <= bus.data_ack ? 1'b0 : (ready_q ? 1'b1 : ovr_q);
        end else if (bus.data_ack && ready_q) begin
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
        end
    end

    assign bus.data_out    = dout_q;
    assign bus.data_ready  = ready_q;
    assign bus.parity_err  = perr_q;
    assign bus.frame_err   = ferr_q;
    assign bus.overrun_err = ovr_q;
    assign bus.break_det   = brk_q;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default 8N1 instance plus a 7-bit
// even-parity instance, sample_tick every 4 clocks (64 clocks per bit).
module tb_uart_rx_param;
    logic       clk_100MHz = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] tcnt = 2'd0;
    logic       tick = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         lat = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    always @(posedge clk_100MHz) begin
        tcnt <= tcnt + 2'd1;
        tick <= (tcnt == 2'd3);
    end

    uart_rx_param_if #(.DBITS(8)) if0 ();
    uart_rx_param_if #(.DBITS(7)) if1 ();
    assign if0.sample_tick = tick;
    assign if1.sample_tick = tick;

    uart_rx_param #(.DBITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk_100MHz(clk_100MHz), .reset(reset), .bus(if0.slave));
    uart_rx_param #(.DBITS(7), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) dut1 (
        .clk_100MHz(clk_100MHz), .reset(reset), .bus(if1.slave));

    task automatic clocks(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    task automatic set_rx(input int w, input logic v);
        if (w == 0) if0.rx = v;
        else        if1.rx = v;
    endtask

    task automatic ack(input int w);
        if (w == 0) if0.data_ack = 1'b1;
        else        if1.data_ack = 1'b1;
        clocks(1);
        if0.data_ack = 1'b0;
        if1.data_ack = 1'b0;
    endtask

    task automatic align();
        do begin
            @(posedge clk_100MHz);
            #1;
        end while (tcnt != 2'd0);
    endtask

    task automatic drive_bit(input int w, input logic v, input bit glitch);
        set_rx(w, v);
        if (glitch) begin
            clocks(28);
            set_rx(w, ~v);
            clocks(4);
            set_rx(w, v);
            clocks(32);
        end else begin
            clocks(64);
        end
    endtask

    task automatic send_frame(input int w, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic pbit, input logic stopv,
                              input bit glitch);
        drive_bit(w, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(w, data[i], glitch);
        if (has_par) drive_bit(w, pbit, glitch);
        drive_bit(w, stopv, 1'b0);
        set_rx(w, 1'b1);
    endtask

    task automatic test_reset();
        clocks(3);
        n_cmp++; if (if0.data_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b want=0", if0.data_ready); end
        n_cmp++; if (if0.data_out !== 8'h00) begin n_bad++; $display("FAIL rst_data got=%h want=00", if0.data_out); end
        n_cmp++; if ({if0.parity_err, if0.frame_err, if0.overrun_err, if0.break_det} !== 4'b0000) begin
            n_bad++; $display("FAIL rst_flags got=%b want=0000", {if0.parity_err, if0.frame_err, if0.overrun_err, if0.break_det}); end
        n_cmp++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b want=0", if0.busy); end
        reset = 1'b0;
        clocks(8);
    endtask

    task automatic test_basic();
        align();
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        clocks(4);
        n_cmp++; if (if0.data_out !== 8'hA5) begin n_bad++; $display("FAIL a5_data got=%h want=a5", if0.data_out); end
        n_cmp++; if (if0.data_ready !== 1'b1) begin n_bad++; $display("FAIL a5_ready got=%b want=1", if0.data_ready); end
        n_cmp++; if ({if0.parity_err, if0.frame_err, if0.overrun_err, if0.break_det} !== 4'b0000) begin
            n_bad++; $display("FAIL a5_flags got=%b want=0000", {if0.parity_err, if0.frame_err, if0.overrun_err, if0.break_det}); end
        n_cmp++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL a5_busy got=%b want=0", if0.busy); end
        ack(0);
        n_cmp++; if (if0.data_ready !== 1'b0) begin n_bad++; $display("FAIL a5_ack_ready got=%b want=0", if0.data_ready); end
        n_cmp++; if (if0.data_out !== 8'hA5) begin n_bad++; $display("FAIL a5_ack_hold got=%h want=a5", if0.data_out); end
    endtask

    task automatic test_start_glitch();
        align();
        set_rx(0, 1'b0);
        clocks(20);
        n_cmp++; if (if0.busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_hi got=%b want=1", if0.busy); end
        set_rx(0, 1'b1);
        clocks(40);
        n_cmp++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_lo got=%b want=0", if0.busy); end
        n_cmp++; if (if0.data_ready !== 1'b0) begin n_bad++; $display("FAIL glitch_ready got=%b want=0", if0.data_ready); end
        clocks(64);
    endtask

    task automatic test_parity();
        align();
        send_frame(1, 9'h055, 7, 1'b1, 1'b1, 1'b1, 1'b0);
        clocks(4);
        n_cmp++; if (if1.data_out !== 7'h55) begin n_bad++; $display("FAIL par1_data got=%h want=55", if1.data_out); end
        n_cmp++; if (if1.parity_err !== 1'b1) begin n_bad++; $display("FAIL par1_err got=%b want=1", if1.parity_err); end
        ack(1);
        clocks(64);
        align();
        send_frame(1, 9'h055, 7, 1'b1, 1'b0, 1'b1, 1'b0);
        clocks(4);
        n_cmp++; if (if1.data_ready !== 1'b1) begin n_bad++; $display("FAIL par0_ready got=%b want=1", if1.data_ready); end
        n_cmp++; if (if1.parity_err !== 1'b0) begin n_bad++; $display("FAIL par0_err got=%b want=0", if1.parity_err); end
        ack(1);
    endtask

    task automatic test_frame_err();
        align();
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        clocks(10);
        n_cmp++; if (if0.data_out !== 8'h3C) begin n_bad++; $display("FAIL fe_data got=%h want=3c", if0.data_out); end
        n_cmp++; if ({if0.frame_err, if0.break_det} !== 2'b10) begin
            n_bad++; $display("FAIL fe_flags got=%b want=10", {if0.frame_err, if0.break_det}); end
        n_cmp++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL fe_busy got=%b want=0", if0.busy); end
        ack(0);
        clocks(64);
        align();
        send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        clocks(4);
        n_cmp++; if (if0.data_out !== 8'h12) begin n_bad++; $display("FAIL fe2_data got=%h want=12", if0.data_out); end
        n_cmp++; if (if0.frame_err !== 1'b0) begin n_bad++; $display("FAIL fe2_err got=%b want=0", if0.frame_err); end
        ack(0);
        clocks(64);
    endtask

    task automatic test_break();
        align();
        set_rx(0, 1'b0);
        clocks(20 * 64);
        n_cmp++; if (if0.data_ready !== 1'b1) begin n_bad++; $display("FAIL brk_ready got=%b want=1", if0.data_ready); end
        n_cmp++; if (if0.data_out !== 8'h00) begin n_bad++; $display("FAIL brk_data got=%h want=00", if0.data_out); end
        n_cmp++; if ({if0.frame_err, if0.break_det} !== 2'b11) begin
            n_bad++; $display("FAIL brk_flags got=%b want=11", {if0.frame_err, if0.break_det}); end
        n_cmp++; if (if0.busy !== 1'b1) begin n_bad++; $display("FAIL brk_busy_hi got=%b want=1", if0.busy); end
        ack(0);
        set_rx(0, 1'b1);
        clocks(64);
        n_cmp++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL brk_busy_lo got=%b want=0", if0.busy); end
        n_cmp++; if (if0.data_ready !== 1'b0) begin n_bad++; $display("FAIL brk_second got=%b want=0", if0.data_ready); end
    endtask

    task automatic test_overrun();
        int cnt;
        cnt = 0;
        align();
        fork
            send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                while (if0.data_ready !== 1'b1 && cnt < 2000) begin
                    @(posedge clk_100MHz);
                    #1;
                    cnt++;
                end
            end
        join
        lat = cnt;
        n_cmp++; if (cnt >= 2000) begin n_bad++; $display("FAIL ovr_first_timeout got=%0d want<2000", cnt); end
        clocks(64);
        align();
        send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        clocks(4);
        n_cmp++; if (if0.data_out !== 8'h22) begin n_bad++; $display("FAIL ovr_data got=%h want=22", if0.data_out); end
        n_cmp++; if (if0.overrun_err !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got=%b want=1", if0.overrun_err); end
        ack(0);
        n_cmp++; if ({if0.data_ready, if0.overrun_err} !== 2'b00) begin
            n_bad++; $display("FAIL ovr_ack got=%b want=00", {if0.data_ready, if0.overrun_err}); end
        clocks(64);
    endtask

    task automatic test_back_to_back();
        align();
        send_frame(0, 9'h033, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        clocks(64);
        n_cmp++; if (if0.data_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_pre_ready got=%b want=1", if0.data_ready); end
        align();
        fork
            send_frame(0, 9'h044, 8, 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                repeat (lat - 1) @(posedge clk_100MHz);
                #1 if0.data_ack = 1'b1;
                @(posedge clk_100MHz);
                #1 if0.data_ack = 1'b0;
            end
        join
        clocks(4);
        n_cmp++; if (if0.data_out !== 8'h44) begin n_bad++; $display("FAIL b2b_data got=%h want=44", if0.data_out); end
        n_cmp++; if ({if0.data_ready, if0.overrun_err} !== 2'b10) begin
            n_bad++; $display("FAIL b2b_ready_ovr got=%b want=10", {if0.data_ready, if0.overrun_err}); end
        ack(0);
        clocks(64);
    endtask

    task automatic test_majority();
        align();
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b1);
        clocks(4);
        n_cmp++; if (if0.data_out !== 8'h5A) begin n_bad++; $display("FAIL maj_data got=%h want=5a", if0.data_out); end
        n_cmp++; if ({if0.data_ready, if0.frame_err, if0.break_det} !== 3'b100) begin
            n_bad++; $display("FAIL maj_flags got=%b want=100", {if0.data_ready, if0.frame_err, if0.break_det}); end
        ack(0);
    endtask

    initial begin
        if0.rx = 1'b1; if0.data_ack = 1'b0;
        if1.rx = 1'b1; if1.data_ack = 1'b0;
        test_reset();
        test_basic();
        test_start_glitch();
        test_parity();
        test_frame_err();
        test_break();
        test_overrun();
        test_back_to_back();
        test_majority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
